// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered bitwise logic unit with valid/ready handshake.
// Eight bitwise functions over two WIDTH-bit operands, one result register
// stage, registered all-ones / any-one flags of the result.
// Optional accepted-transaction counter: define LOGIC_PIPE_STATS_EN.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any
`ifdef LOGIC_PIPE_STATS_EN
   ,output logic [CNT_W-1:0] txn_count
`endif
);

    // Reject meaningless widths at elaboration.
    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("logic_gate_pipe: WIDTH and CNT_W must be >= 1");
    end

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    logic [WIDTH-1:0] r_y;
    logic             r_all;
    logic             r_any;
    logic             r_vld;
    logic [WIDTH-1:0] w_f;
    logic             w_ready;
    logic             w_accept;

    // The stage can take new operands when empty or when its result leaves now.
    assign w_ready  = !r_vld || out_ready;
    assign w_accept = in_valid && w_ready;

    // Selected bitwise function; the last op code (PASS) is the default arm.
    always_comb begin
        w_f = a;
        case (op)
            OP_AND:  w_f = a & b;
            OP_OR:   w_f = a | b;
            OP_XOR:  w_f = a ^ b;
            OP_NAND: w_f = ~(a & b);
            OP_NOR:  w_f = ~(a | b);
            OP_XNOR: w_f = ~(a ^ b);
            OP_NOT:  w_f = ~a;
            default: w_f = a;
        endcase
    end

    // Result register: load on accept, otherwise drop valid once consumed.
    // Data and flags are kept after a drain so the outputs never go X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_y   <= '0;
            r_all <= 1'b0;
            r_any <= 1'b0;
        end else if (w_accept) begin
            r_vld <= 1'b1;
            r_y   <= w_f;
            r_all <= &w_f;
            r_any <= |w_f;
        end else if (out_ready) begin
            r_vld <= 1'b0;
        end
    end

`ifdef LOGIC_PIPE_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of accepted transactions; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign txn_count = r_cnt;
`endif

    assign in_ready  = w_ready;
    assign out_valid = r_vld;
    assign y         = r_y;
    assign y_all     = r_all;
    assign y_any     = r_any;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe. Accepted operands push a predicted
// result; a negedge monitor compares and pops it when it is consumed.
// Define LOGIC_PIPE_STATS_EN to also check txn_count.
module tb_logic_gate_pipe;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0] y;
        logic         all;
        logic         any;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    op = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  y;
    logic          y_all;
    logic          y_any;
`ifdef LOGIC_PIPE_STATS_EN
    logic [CW-1:0] txn_count;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q[$];
    int   m_cnt = 0;

    logic_gate_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_all(y_all), .y_any(y_any)
`ifdef LOGIC_PIPE_STATS_EN
       ,.txn_count(txn_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: per-bit truth table indexed by {a_bit, b_bit}; flags by popcount.
    function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic [2:0] fop);
        res_t       r;
        logic [3:0] tt;
        int         ones;
        case (fop)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        ones = 0;
        for (int i = 0; i < W; i++) begin
            r.y[i] = tt[{fa[i], fb[i]}];
            if (r.y[i]) ones++;
        end
        r.all = (ones == W);
        r.any = (ones != 0);
        return r;
    endfunction

    // Monitor: check against model state, retire consumed result, record accept.
    always @(negedge clk) begin
        logic m_rdy;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
        end else begin
            m_rdy = (q.size() == 0) || out_ready;
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, m_rdy);
            if (q.size() != 0 && out_valid) begin
                chk("y", y, q[0].y);
                chk("y_all", y_all, q[0].all);
                chk("y_any", y_any, q[0].any);
                if (out_ready) void'(q.pop_front());
            end
`ifdef LOGIC_PIPE_STATS_EN
            chk("txn_count", txn_count, m_cnt);
`endif
            if (in_valid && m_rdy) begin
                q.push_back(model(a, b, op));
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [2:0] top, input logic rdy);
        in_valid  = v;
        a         = ta;
        b         = tb;
        op        = top;
        out_ready = rdy;
    endtask

    initial begin
        logic [W-1:0] ops_exp [8];
        int           cnt_exp [5];
        ops_exp = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
        cnt_exp = '{1, 2, 3, 3, 3};

        // Reset held with a transaction offered.
        drive(1'b1, 8'h12, 8'h34, 3'd1, 1'b0);
        tick();
        tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst y", y, 0);
        chk("rst y_all", y_all, 0);
        chk("rst y_any", y_any, 0);
`ifdef LOGIC_PIPE_STATS_EN
        chk("rst txn_count", txn_count, 0);
`endif

        // First accept.
        rst_n = 1'b1;
        drive(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b1);
        tick();
        chk("first y", y, 8'h30);
        chk("first y_all", y_all, 0);
        chk("first y_any", y_any, 1);
        chk("first out_valid", out_valid, 1);

        // All ops back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hA5, 8'h0F, 3'(i), 1'b1);
            #1 chk("ops in_ready", in_ready, 1);
            tick();
            chk("ops y", y, ops_exp[i]);
        end

        // Back-pressure: hold 0xFF for three stalled edges.
        drive(1'b1, 8'hFF, 8'hFF, 3'd0, 1'b1);
        tick();
        drive(1'b1, 8'h00, 8'h00, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall in_ready", in_ready, 0);
            chk("stall y", y, 8'hFF);
            chk("stall y_all", y_all, 1);
            tick();
        end
        chk("stall out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("refill y", y, 8'h00);
        chk("refill out_valid", out_valid, 1);
        chk("refill y_any", y_any, 0);

        // Load a distinct value, then drain it.
        drive(1'b1, 8'h3C, 8'h99, 3'd7, 1'b1);
        tick();
        chk("pass y", y, 8'h3C);
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", out_valid, 0);
        chk("drain y hold", y, 8'h3C);
        tick();
        tick();
        chk("idle out_valid", out_valid, 0);

        // Reset while a result is stalled.
        drive(1'b1, 8'h81, 8'h00, 3'd1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        chk("held out_valid", out_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst out_valid", out_valid, 0);
        chk("midrst y", y, 0);
        chk("midrst in_ready", in_ready, 1);
`ifdef LOGIC_PIPE_STATS_EN
        chk("midrst txn_count", txn_count, 0);
`endif
        rst_n = 1'b1;

        // Counter saturation over five accepts.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 3'($urandom), 1'b1);
            tick();
`ifdef LOGIC_PIPE_STATS_EN
            chk("stats txn_count", txn_count, cnt_exp[i]);
`else
            chk("stats out_valid", out_valid, 1);
`endif
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef LOGIC_PIPE_STATS_EN
        chk("stats rst txn_count", txn_count, 0);
`endif

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, W'($urandom), W'($urandom), 3'($urandom),
                  ($urandom % 3) != 0);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        tick();
        tick();
        tick();
        chk("final out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, registered bitwise logic unit: successor to the single-bit two-input gate blocks.
- Computes one of eight bitwise functions over two WIDTH-bit operands; the operation is selectable per transaction.
- One pipeline register stage with valid/ready handshake on both sides, plus registered reduction flags.
- Sits between operand sources and downstream datapath stages that require back-pressure.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- CNT_W, 16, width of transaction counter (optional feature only, ≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand transaction offered
- in_ready  output  1  block can accept a transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select, sampled with operands
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream accepts result this cycle
- y  output  WIDTH  registered result
- y_all  output  1  registered reduction-AND of result (all ones)
- y_any  output  1  registered reduction-OR of result (any one)
- txn_count  output  CNT_W  accepted-transaction counter (present only with LOGIC_PIPE_STATS_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst_n is sampled only on the rising clk edge.
- Reset (rst_n=0 at the clk edge): out_valid=0, y=0, y_all=0, y_any=0, txn_count=0. Reset overrides any simultaneous handshake, including mid-transfer; a pending result is discarded.
- Op encoding (f = function applied to a, b):
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XNOR: ~(a^b)
  - 6 NOT: ~a, b ignored
  - 7 PASS: a, b ignored
- in_ready is combinational: in_ready = !out_valid || out_ready. It does not depend on in_valid.
- Accept condition: in_valid && in_ready at the rising edge. On accept:
  - y <= f
  - y_all <= &f
  - y_any <= |f
  - out_valid <= 1
- Latency: exactly 1 cycle from accept to out_valid=1 with the result.
- Drain without refill: out_valid && out_ready && !(in_valid && in_ready) gives out_valid <= 0. y, y_all and y_any hold their last values.
- Simultaneous consume and accept: in_valid=1, out_valid=1, out_ready=1. The old result is consumed and the new result is loaded in the same edge; out_valid stays 1. Full throughput is one transaction per cycle.
- Stall: out_valid=1, out_ready=0 gives in_ready=0. y, y_all, y_any and out_valid hold stable; a, b and op are ignored.
- out_valid never drops without out_ready; a held result is never overwritten.
- All arithmetic is bitwise; no carries. WIDTH=1 degenerates to a registered single gate, with y_all = y_any = y.
- No X propagation on outputs after reset, whatever values a, b and op take.

Optional Feature:
- Macro: LOGIC_PIPE_STATS_EN.
- Defined:
  - txn_count port exists; it increments by 1 on every accept.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Cleared only by reset.
- Not defined:
  - txn_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then check the first accept (WIDTH=8):
  - Hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, y=0x00, y_all=0, y_any=0, txn_count=0.
  - Release reset; a=0xF0, b=0x3C, op=0 accepted → next cycle y=0x30, y_all=0, y_any=1, out_valid=1.
- All ops with out_ready=1 held, a=0xA5, b=0x0F, op=0..7 on consecutive cycles:
  - y sequence 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0x5A, 0xA5, one per cycle.
  - in_ready=1 throughout.
- Back-pressure:
  - Accept a=0xFF, b=0xFF, op=0, then drive out_ready=0 for 3 cycles while offering a=0x00, op=1.
  - Expected: in_ready=0, y=0xFF, y_all=1 stable for 3 cycles.
  - Raise out_ready → 0xFF consumed and 0x00 loaded on the same edge; out_valid stays 1.
- Drain:
  - With out_valid=1, set in_valid=0 and out_ready=1 → out_valid=0 next cycle, y holds its value.
  - Two idle cycles → no spurious out_valid.
- Reset mid-operation: rst_n=0 for one cycle while out_valid=1 and out_ready=0 → out_valid=0 and y=0 after the edge, and in_ready=1.
- Stats (LOGIC_PIPE_STATS_EN, CNT_W=2):
  - 5 accepts → txn_count sequence 1, 2, 3, 3, 3 (saturates).
  - Reset → 0.
  - Rebuild without the macro; the same bench minus the txn_count checks passes.
